// File: rtl/ternary_matvec_lanes_if.sv
// Bundles the start handshake, vector memory port, DDR read port and status flags.
// No latency of its own; a pure wiring container.
// Backpressure lives in the engine: in_ready_o gates starts, one DDR read in flight.
interface ternary_matvec_lanes_if #(
  parameter int FP_W   = 16,
  parameter int DDR_W  = 64,
  parameter int ADDR_W = 32,
  parameter int VA_W   = 6
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic                     accumulate_i;
  logic [ADDR_W-1:0]        matrix_addr_i;
  logic [VA_W-1:0]          vector_addr_o;
  logic signed [FP_W-1:0]   vector_r_data_i;
  logic                     vector_w_en_o;
  logic signed [FP_W-1:0]   vector_w_data_o;
  logic [ADDR_W-1:0]        ddr_address_o;
  logic                     ddr_r_en_o;
  logic                     ddr_r_valid_i;
  logic [DDR_W-1:0]         ddr_r_data_i;
  logic                     done_o;
  logic                     sat_o;
  logic                     err_o;

  // Engine side
  modport slave (
    input  in_valid_i, accumulate_i, matrix_addr_i, vector_r_data_i,
           ddr_r_valid_i, ddr_r_data_i,
    output in_ready_o, vector_addr_o, vector_w_en_o, vector_w_data_o,
           ddr_address_o, ddr_r_en_o, done_o, sat_o, err_o
  );

  // Requester / memory side
  modport master (
    output in_valid_i, accumulate_i, matrix_addr_i, vector_r_data_i,
           ddr_r_valid_i, ddr_r_data_i,
    input  in_ready_o, vector_addr_o, vector_w_en_o, vector_w_data_o,
           ddr_address_o, ddr_r_en_o, done_o, sat_o, err_o
  );
endinterface

// File: rtl/ternary_matvec_lanes.sv
// Ternary matrix x vector engine: streams 2-bit weights from DDR, LANES cells per cycle.
// Latency ROWS*COLS/LANES + ROWS + 1 cycles from start plus DDR stall cycles.
// Compute stalls on an empty word FIFO; only one DDR read is ever outstanding.
module ternary_matvec_lanes #(
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int LANES      = 4,
  parameter int FP_W       = 16,
  parameter int ACC_W      = 2*FP_W,
  parameter int DDR_W      = 64,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  ternary_matvec_lanes_if.slave bus
);

  localparam int CPW   = DDR_W / 2;                     // cells per DDR word
  localparam int GPW   = CPW / LANES;                   // lane groups per word
  localparam int NW    = ROWS * COLS * 2 / DDR_W;       // words per matrix
  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int VA_W  = (MAXRC > 1) ? $clog2(MAXRC) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int NW_W  = $clog2(NW + 1);
  localparam int G_W   = (GPW > 1) ? $clog2(GPW) : 1;

  localparam logic signed [ACC_W:0] FP_MAX_X = (ACC_W+1)'(2**(FP_W-1) - 1);
  localparam logic signed [ACC_W:0] FP_MIN_X = (ACC_W+1)'(-(2**(FP_W-1)));
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITEBACK, S_DONE} state_t;

  state_t                   state_q;
  logic                     accum_q;
  logic [ADDR_W-1:0]        base_q;
  logic [G_W-1:0]           gidx_q;
  logic [VA_W-1:0]          row_q;
  logic [VA_W-1:0]          col_q;
  logic                     sat_q;
  logic                     err_q;
  logic signed [ACC_W-1:0]  acc_q [ROWS];

  logic                     out_q;
  logic [NW_W-1:0]          issued_q;
  logic [DDR_W-1:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         cnt_q;

  logic start, issue, push, consume, pop, row_last, col_last;

  // Saturate a widened value into the vector element range
  function automatic logic signed [FP_W-1:0] clamp_fp(input logic signed [ACC_W:0] x);
    if (x > FP_MAX_X)      return FP_MAX_X[FP_W-1:0];
    else if (x < FP_MIN_X) return FP_MIN_X[FP_W-1:0];
    else                   return x[FP_W-1:0];
  endfunction

  assign start    = bus.in_valid_i && (state_q == S_IDLE);
  assign issue    = (state_q == S_COMPUTE) && !out_q && (issued_q != NW_W'(NW)) &&
                    ((int'(cnt_q) + int'(out_q)) < FIFO_DEPTH);
  // A response only counts when this engine has a read in flight
  assign push     = bus.ddr_r_valid_i && out_q;
  assign consume  = (state_q == S_COMPUTE) && (cnt_q != '0);
  assign pop      = consume && (gidx_q == G_W'(GPW - 1));
  assign row_last = (row_q == VA_W'(ROWS - LANES));
  assign col_last = (col_q == VA_W'(COLS - 1));

  logic [DDR_W-1:0]         grp_bits;
  logic signed [ACC_W:0]    v_x;
  logic signed [ACC_W:0]    prior_x;
  logic signed [ACC_W:0]    sum_x;
  logic [1:0]               code_d;
  int                       ridx;
  logic signed [ACC_W-1:0]  acc_upd_d [LANES];
  logic                     grp_sat_d;
  logic                     grp_err_d;

  // Per-lane ternary multiply-accumulate for the group at the FIFO head
  always_comb begin
    grp_bits  = fifo_mem_q[rd_ptr_q] >> (2 * LANES * int'(gidx_q));
    v_x       = (ACC_W+1)'(bus.vector_r_data_i);
    grp_sat_d = 1'b0;
    grp_err_d = 1'b0;
    prior_x   = '0;
    sum_x     = '0;
    code_d    = '0;
    ridx      = 0;
    for (int j = 0; j < LANES; j++) begin
      acc_upd_d[j] = '0;
      code_d  = grp_bits[2*j +: 2];
      ridx    = (int'(row_q) + j) % ROWS;
      // First column starts from zero instead of stale accumulator contents
      prior_x = (col_q == '0) ? '0 : (ACC_W+1)'(acc_q[ridx]);
      case (code_d)
        2'b01:   sum_x = prior_x + v_x;
        2'b11:   sum_x = prior_x - v_x;
        2'b10: begin
          sum_x     = prior_x;
          grp_err_d = 1'b1;
        end
        default: sum_x = prior_x;
      endcase
      if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
        grp_sat_d    = 1'b1;
        acc_upd_d[j] = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_upd_d[j] = sum_x[ACC_W-1:0];
      end
    end
  end

  logic signed [ACC_W:0]    a_x;
  logic signed [ACC_W:0]    s_x;
  logic signed [FP_W-1:0]   c1_d;
  logic signed [FP_W-1:0]   c2_d;
  logic signed [FP_W-1:0]   wb_data_d;
  logic                     wb_sat_d;

  // Writeback value: clamped accumulator, optionally added onto the stored element
  always_comb begin
    a_x       = (ACC_W+1)'(acc_q[row_q]);
    c1_d      = clamp_fp(a_x);
    s_x       = (ACC_W+1)'(bus.vector_r_data_i) + (ACC_W+1)'(c1_d);
    c2_d      = clamp_fp(s_x);
    wb_sat_d  = ((ACC_W+1)'(c1_d) != a_x);
    wb_data_d = c1_d;
    if (accum_q) begin
      wb_data_d = c2_d;
      wb_sat_d  = wb_sat_d || ((ACC_W+1)'(c2_d) != s_x);
    end
  end

  // Control FSM: walks groups column by column, then writes rows back
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q <= S_IDLE;
      accum_q <= 1'b0;
      base_q  <= '0;
      gidx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_COMPUTE;
            accum_q <= bus.accumulate_i;
            base_q  <= bus.matrix_addr_i;
            gidx_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_COMPUTE: begin
          if (consume) begin
            sat_q  <= sat_q | grp_sat_d;
            err_q  <= err_q | grp_err_d;
            gidx_q <= pop ? '0 : gidx_q + 1'b1;
            if (row_last) begin
              row_q <= '0;
              if (col_last) state_q <= S_WRITEBACK;
              else          col_q   <= col_q + 1'b1;
            end else begin
              row_q <= row_q + VA_W'(LANES);
            end
          end
        end
        S_WRITEBACK: begin
          sat_q <= sat_q | wb_sat_d;
          if (row_q == VA_W'(ROWS - 1)) state_q <= S_DONE;
          else                          row_q   <= row_q + 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Accumulator bank: contents are meaningless until the first column rewrites them
  always_ff @(posedge clk_i) begin
    if (consume) begin
      for (int j = 0; j < LANES; j++) begin
        acc_q[(int'(row_q) + j) % ROWS] <= acc_upd_d[j];
      end
    end
  end

  // DDR fetcher and word FIFO bookkeeping
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      out_q    <= 1'b0;
      issued_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (start)      issued_q <= '0;
      else if (issue) issued_q <= issued_q + 1'b1;
      if (issue)      out_q <= 1'b1;
      else if (push)  out_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.ddr_r_data_i;
  end

  // Vector port address: column while computing, row while writing back
  always_comb begin
    case (state_q)
      S_COMPUTE:   bus.vector_addr_o = col_q;
      S_WRITEBACK: bus.vector_addr_o = row_q;
      default:     bus.vector_addr_o = '0;
    endcase
  end

  assign bus.in_ready_o      = (state_q == S_IDLE);
  assign bus.done_o          = (state_q == S_DONE);
  assign bus.vector_w_en_o   = (state_q == S_WRITEBACK);
  assign bus.vector_w_data_o = (state_q == S_WRITEBACK) ? wb_data_d : '0;
  assign bus.ddr_r_en_o      = issue;
  assign bus.ddr_address_o   = issue ? (base_q + ADDR_W'(issued_q)) : '0;
  assign bus.sat_o           = sat_q;
  assign bus.err_o           = err_q;

endmodule

// File: doc/ternary_matvec_lanes.md
TERNARY_MATVEC_LANES -- requirements
Module: ternary_matvec_lanes

Interface
REQ-001 SHALL have parameter ROWS, default 64, output vector length (multiple of LANES).
REQ-002 SHALL have parameter COLS, default 64, input vector length.
REQ-003 SHALL have parameter LANES, default 4, matrix cells consumed per cycle; DDR_W/2 SHALL be a multiple of LANES.
REQ-004 SHALL have parameter FP_W, default 16, signed vector element width.
REQ-005 SHALL have parameter ACC_W, default 2*FP_W, signed accumulator width.
REQ-006 SHALL have parameter DDR_W, default 64, DDR word width.
REQ-007 SHALL have parameter ADDR_W, default 32, DDR word-address width.
REQ-008 SHALL have parameter FIFO_DEPTH, default 4, matrix word FIFO depth (power of 2).
REQ-009 One clock; reset is asynchronous and active-high.
REQ-010 clk_i  in  1  clock.
REQ-011 rst_ni  in  1  asynchronous active-high reset.
REQ-012 in_valid_i  in  1  start request.
REQ-013 in_ready_o  out  1  high only in IDLE.
REQ-014 accumulate_i  in  1  sampled at start: 1 = add result to existing vector, 0 = overwrite.
REQ-015 matrix_addr_i  in  ADDR_W  first matrix word address, sampled at start.
REQ-016 vector_addr_o  out  clog2(max(ROWS,COLS))  vector memory address.
REQ-017 vector_r_data_i  in  FP_W  combinational read data for vector_addr_o.
REQ-018 vector_w_en_o / vector_w_data_o  out  1 / FP_W  vector write strobe and data.
REQ-019 ddr_address_o / ddr_r_en_o  out  ADDR_W / 1  single-cycle read request.
REQ-020 ddr_r_valid_i / ddr_r_data_i  in  1 / DDR_W  read response.
REQ-021 done_o  out  1  one-cycle completion pulse.
REQ-022 sat_o / err_o  out  1 / 1  sticky saturation / invalid-code flags, cleared at start.

Function
REQ-023 Cell encoding 2-bit two's complement in DDR word, cell k at bits [2k+1:2k]: 00=0, 01=+1, 11=-1, 10=invalid (contributes 0, sets err_o).
REQ-024 Matrix column-major: cell n = row (n mod ROWS), column (n div ROWS); word w holds cells w*DDR_W/2 onward; total words = ROWS*COLS*2/DDR_W.
REQ-025 States IDLE -> COMPUTE on in_valid_i&&in_ready_o; COMPUTE -> WRITEBACK after last cell group; WRITEBACK -> DONE after row ROWS-1 written; DONE -> IDLE unconditionally (1 cycle, done_o=1).
REQ-026 DDR fetcher: at most one outstanding request; issues ddr_r_en_o only in COMPUTE when FIFO occupancy + outstanding < FIFO_DEPTH and words remain; addresses matrix_addr_i+0,+1,... in order.
REQ-027 ddr_r_valid_i with no outstanding request SHALL be ignored.
REQ-028 Each COMPUTE cycle with FIFO data: vector_addr_o=column c, LANES rows r..r+LANES-1 updated acc[r+j] = sat_ACC(acc[r+j] + t_j*vector_r_data_i); c=0 uses 0 as prior acc; no update (stall) when FIFO empty.
REQ-029 FIFO word popped after its last LANES group consumed; push and pop same cycle legal when full.
REQ-030 Any accumulator or output saturation SHALL set sat_o.
REQ-031 WRITEBACK: one row per cycle, vector_addr_o=row, vector_w_en_o=1, data = clamp_FP(acc) (accumulate_i=0) or clamp_FP(vector_r_data_i + clamp_FP(acc)) (accumulate_i=1).
REQ-032 Minimum latency start to done_o = ROWS*COLS/LANES + ROWS + 1 cycles plus DDR stalls; in_ready_o high cycle after done_o.
REQ-033 in_valid_i outside IDLE SHALL be ignored; vector_w_en_o SHALL be 0 outside WRITEBACK; ddr_r_en_o 0 outside COMPUTE.

Reset
REQ-034 Reset SHALL force IDLE, empty FIFO, clear outstanding, in_ready_o=1, all other outputs 0 (addresses/data 0), sat_o=err_o=0, acc contents don't-care.
REQ-035 Reset mid-operation SHALL abort without further vector writes; late DDR responses after reset ignored.

Verification (ROWS=COLS=4, LANES=2, FP_W=8, ACC_W=16, DDR_W=16)
REQ-036 Identity matrix, vector [10,-20,30,-40], accumulate=0 -> two DDR reads, vector unchanged, done_o once, sat_o=err_o=0.
REQ-037 All -1 matrix, vector all 127 -> all rows -128, sat_o=1.
REQ-038 Identity, vector [1,2,3,4], accumulate=1 -> [2,4,6,8].
REQ-039 ddr_r_valid_i delayed 10 cycles per read -> no second ddr_r_en_o while outstanding, result identical to REQ-036.
REQ-040 Reset asserted mid-COMPUTE -> in_ready_o=1, no vector writes; subsequent REQ-036 run correct.
REQ-041 Matrix with code 10 at cell 0, rest identity -> row 0 = 0, err_o=1.
